// File: rtl/bram_write_arbiter.sv
// BRAM write arbiter: one recycle (priority) source plus NUM_CH round-robin
// request channels feeding a single registered BRAM write command port.
// Priority wins are capped at PRI_MAX in a row while channels wait.
module bram_write_arbiter #(
   parameter int NUM_CH  = 16,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 64,
   parameter int PRI_MAX = 4,
   localparam int BE_W   = DATA_W / 8,
   localparam int SRC_W  = $clog2(NUM_CH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        req_valid,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_data,
   input  logic [NUM_CH*BE_W-1:0]   req_be,
   output logic [NUM_CH-1:0]        req_grant,
   input  logic                     pri_valid,
   input  logic [ADDR_W-1:0]        pri_addr,
   input  logic [DATA_W-1:0]        pri_data,
   input  logic [BE_W-1:0]          pri_be,
   output logic                     pri_ready,
   output logic                     out_valid,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_data,
   output logic [BE_W-1:0]          out_be,
   output logic [SRC_W-1:0]         out_src,
   input  logic                     out_ready
);

   localparam int IDX_W = SRC_W - 1;

   logic [NUM_CH-1:0] base_q, base_d;
   logic [3:0]        pri_cnt_q, pri_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [BE_W-1:0]   out_be_q, out_be_d;
   logic [SRC_W-1:0]  out_src_q, out_src_d;

   logic              accept;
   logic              any_req;
   logic              force_ch;
   logic              take_pri;
   logic              take_ch;
   logic [IDX_W-1:0]  base_idx;
   logic [IDX_W-1:0]  grant_idx;
   logic              found;
   logic [NUM_CH-1:0] grant;

   // Round-robin search: first requesting channel at or above base, wrapping
   always_comb begin
      int unsigned      pos;
      logic [IDX_W-1:0] idx_v;
      base_idx  = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = 0;
      idx_v     = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (base_q[i]) base_idx = IDX_W'(i);
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         pos = 32'(base_idx) + k;
         if (pos >= NUM_CH) pos = pos - NUM_CH;
         idx_v = IDX_W'(pos);
         if (!found && req_valid[idx_v]) begin
            found     = 1'b1;
            grant_idx = idx_v;
         end
      end
   end

   // Source selection, handshakes and next state of base / priority counter
   always_comb begin
      accept    = !out_valid_q || out_ready;
      any_req   = |req_valid;
      force_ch  = (pri_cnt_q == 4'(PRI_MAX)) && any_req;
      take_pri  = rst_n && accept && pri_valid && !force_ch;
      take_ch   = rst_n && accept && !take_pri && any_req;
      grant     = take_ch ? (NUM_CH'(1) << grant_idx) : '0;
      req_grant = grant;
      pri_ready = take_pri;

      base_d    = base_q;
      pri_cnt_d = pri_cnt_q;
      if (take_ch) begin
         base_d    = {grant[NUM_CH-2:0], grant[NUM_CH-1]};
         pri_cnt_d = '0;
      end else if (take_pri) begin
         pri_cnt_d = any_req ? pri_cnt_q + 4'd1 : '0;
      end
   end

   // Output command register: load on a selection, drain when accepted, else hold
   always_comb begin
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_be_d    = out_be_q;
      out_src_d   = out_src_q;
      if (take_pri) begin
         out_valid_d = 1'b1;
         out_addr_d  = pri_addr;
         out_data_d  = pri_data;
         out_be_d    = pri_be;
         out_src_d   = {1'b1, {IDX_W{1'b0}}};
      end else if (take_ch) begin
         out_valid_d = 1'b1;
         out_addr_d  = req_addr[grant_idx*ADDR_W +: ADDR_W];
         out_data_d  = req_data[grant_idx*DATA_W +: DATA_W];
         out_be_d    = req_be[grant_idx*BE_W +: BE_W];
         out_src_d   = {1'b0, grant_idx};
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q      <= NUM_CH'(1);
         pri_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_be_q    <= '0;
         out_src_q   <= '0;
      end else begin
         base_q      <= base_d;
         pri_cnt_q   <= pri_cnt_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_be_q    <= out_be_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_be    = out_be_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed-vector bench for bram_write_arbiter at default parameters.
module tb_bram_write_arbiter;

   localparam int NUM_CH = 16;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 64;
   localparam int BE_W   = 8;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*DATA_W-1:0] req_data;
   logic [NUM_CH*BE_W-1:0]   req_be;
   logic [NUM_CH-1:0]        req_grant;
   logic                     pri_valid;
   logic [ADDR_W-1:0]        pri_addr;
   logic [DATA_W-1:0]        pri_data;
   logic [BE_W-1:0]          pri_be;
   logic                     pri_ready;
   logic                     out_valid;
   logic [ADDR_W-1:0]        out_addr;
   logic [DATA_W-1:0]        out_data;
   logic [BE_W-1:0]          out_be;
   logic [4:0]               out_src;
   logic                     out_ready;

   bram_write_arbiter #(
      .NUM_CH (NUM_CH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .PRI_MAX(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_addr (req_addr),
      .req_data (req_data),
      .req_be   (req_be),
      .req_grant(req_grant),
      .pri_valid(pri_valid),
      .pri_addr (pri_addr),
      .pri_data (pri_data),
      .pri_be   (pri_be),
      .pri_ready(pri_ready),
      .out_valid(out_valid),
      .out_addr (out_addr),
      .out_data (out_data),
      .out_be   (out_be),
      .out_src  (out_src),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [15:0] rv;
      logic        pv;
      logic        ordy;
      logic [15:0] g;
      logic        pr;
      logic        ov;
      logic [4:0]  src;
      logic [15:0] base;
      logic [3:0]  cnt;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   int n_vec;
   int n_fail;

   function automatic logic [ADDR_W-1:0] ch_addr(input int i);
      return ADDR_W'(5 + i * 7);
   endfunction
   function automatic logic [DATA_W-1:0] ch_data(input int i);
      return 64'hA5 | (64'(i) << 32) | (64'(i) << 56);
   endfunction
   function automatic logic [BE_W-1:0] ch_be(input int i);
      return (i == 3) ? 8'h00 : (8'hFF - 8'(i));
   endfunction

   function automatic vec_t mk(input logic rst, input logic [15:0] rv, input logic pv,
                               input logic ordy, input logic [15:0] g, input logic pr,
                               input logic ov, input logic [4:0] src,
                               input logic [15:0] base, input logic [3:0] cnt);
      vec_t v;
      v.rst = rst; v.rv = rv; v.pv = pv; v.ordy = ordy; v.g = g; v.pr = pr;
      v.ov = ov; v.src = src; v.base = base; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle, check handshakes mid-cycle, then registered outputs after the edge
   task automatic apply(input logic rst, input logic [15:0] rv, input logic pv,
                        input logic ordy, input logic [15:0] g, input logic pr,
                        input logic ov, input logic [4:0] src,
                        input logic [15:0] base, input logic [3:0] cnt);
      rst_n     = rst;
      req_valid = rv;
      pri_valid = pv;
      out_ready = ordy;
      #3;
      check("req_grant", 64'(req_grant), 64'(g));
      check("pri_ready", 64'(pri_ready), 64'(pr));
      @(posedge clk);
      #1;
      n_vec++;
      check("out_valid", 64'(out_valid), 64'(ov));
      check("out_src", 64'(out_src), 64'(src));
      check("base", 64'(dut.base_q), 64'(base));
      check("pri_cnt", 64'(dut.pri_cnt_q), 64'(cnt));
      if (!rst) begin
         check("rst_addr", 64'(out_addr), 64'h0);
         check("rst_data", out_data, 64'h0);
         check("rst_be", 64'(out_be), 64'h0);
      end else if (ov) begin
         if (src[4]) begin
            check("out_addr", 64'(out_addr), 64'(pri_addr));
            check("out_data", out_data, pri_data);
            check("out_be", 64'(out_be), 64'(pri_be));
         end else begin
            check("out_addr", 64'(out_addr), 64'(ch_addr(int'(src[3:0]))));
            check("out_data", out_data, ch_data(int'(src[3:0])));
            check("out_be", 64'(out_be), 64'(ch_be(int'(src[3:0]))));
         end
      end
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = ch_addr(i);
         req_data[i*DATA_W +: DATA_W] = ch_data(i);
         req_be[i*BE_W +: BE_W]       = ch_be(i);
      end
      pri_addr  = 9'h1AB;
      pri_data  = 64'hDEAD_BEEF_0123_4567;
      pri_be    = 8'h5A;
      rst_n     = 1'b0;
      req_valid = '0;
      pri_valid = 1'b0;
      out_ready = 1'b1;

      //              rst   rv        pv    ordy  grant     pr    ov    src     base      cnt
      vecs[0]  = mk(1'b0, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0001, 4'd0);
      vecs[1]  = mk(1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 5'd0,  16'h0002, 4'd0);
      vecs[2]  = mk(1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0002, 4'd0);
      vecs[3]  = mk(1'b1, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 5'd1,  16'h0004, 4'd0);
      vecs[4]  = mk(1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 5'd0,  16'h0002, 4'd0);
      vecs[5]  = mk(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 5'd16, 16'h0002, 4'd1);
      vecs[6]  = mk(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 5'd16, 16'h0002, 4'd2);
      vecs[7]  = mk(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 5'd16, 16'h0002, 4'd3);
      vecs[8]  = mk(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 5'd16, 16'h0002, 4'd4);
      vecs[9]  = mk(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b1, 5'd4,  16'h0020, 4'd0);
      vecs[10] = mk(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 5'd16, 16'h0020, 4'd1);
      vecs[11] = mk(1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 5'd16, 16'h0020, 4'd0);
      vecs[12] = mk(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd16, 16'h0020, 4'd0);
      vecs[13] = mk(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd16, 16'h0020, 4'd0);
      vecs[14] = mk(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd16, 16'h0020, 4'd0);
      vecs[15] = mk(1'b1, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 5'd8,  16'h0200, 4'd0);
      vecs[16] = mk(1'b1, 16'h0008, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b1, 5'd3,  16'h0010, 4'd0);
      vecs[17] = mk(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd3,  16'h0010, 4'd0);
      vecs[18] = mk(1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 5'd3,  16'h0010, 4'd0);
      vecs[19] = mk(1'b1, 16'h4000, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b1, 5'd14, 16'h8000, 4'd0);
      vecs[20] = mk(1'b1, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 5'd0,  16'h0002, 4'd0);
      vecs[21] = mk(1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 5'd1,  16'h0004, 4'd0);
      vecs[22] = mk(1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 5'd16, 16'h0004, 4'd1);
      vecs[23] = mk(1'b0, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0,  16'h0001, 4'd0);

      @(posedge clk);
      #1;
      for (int v = 0; v < NV; v++) begin
         apply(vecs[v].rst, vecs[v].rv, vecs[v].pv, vecs[v].ordy, vecs[v].g, vecs[v].pr,
               vecs[v].ov, vecs[v].src, vecs[v].base, vecs[v].cnt);
      end

      // All channels requesting for 18 cycles after reset: strict rotation 0..15,0,1
      for (int k = 0; k < 18; k++) begin
         apply(1'b1, 16'hFFFF, 1'b0, 1'b1, 16'(1) << (k % 16), 1'b0, 1'b1,
               5'(k % 16), 16'(1) << ((k + 1) % 16), 4'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_write_arbiter.md
BRAM_WRITE_ARBITER -- requirements
Module: bram_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of request channels (2..32).
REQ-002 SHALL have parameter ADDR_W, default 9, BRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 64, data width; BE_W = DATA_W/8 derived; DATA_W multiple of 8.
REQ-004 SHALL have parameter PRI_MAX, default 4, max consecutive priority wins while channel requests wait (1..15).
REQ-005 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port req_valid  in  NUM_CH  per-channel write request.
REQ-008 SHALL have port req_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_data  in  NUM_CH*DATA_W  packed data, same packing.
REQ-010 SHALL have port req_be  in  NUM_CH*BE_W  packed byte enables, same packing.
REQ-011 SHALL have port req_grant  out  NUM_CH  one-hot/zero grant; request consumed in the cycle its bit is 1.
REQ-012 SHALL have ports pri_valid in 1, pri_addr in ADDR_W, pri_data in DATA_W, pri_be in BE_W: recycle (priority) request.
REQ-013 SHALL have port pri_ready  out  1  priority request consumed this cycle.
REQ-014 SHALL have ports out_valid out 1, out_addr out ADDR_W, out_data out DATA_W, out_be out BE_W: registered BRAM write command.
REQ-015 SHALL have port out_src  out  $clog2(NUM_CH)+1  source of command: MSB=1 priority, else channel index.
REQ-016 SHALL have port out_ready  in  1  downstream accepts command.

Function
REQ-017 SHALL compute accept = !out_valid || out_ready; no grant, no pri_ready when accept=0.
REQ-018 SHALL drive req_grant and pri_ready combinationally from current-cycle inputs and state.
REQ-019 SHALL, when accept=1 and pri_valid=1 and not forced-channel, assert pri_ready and keep req_grant=0.
REQ-020 SHALL, when accept=1 and priority not taken and req_valid!=0, grant exactly one channel: first requesting index at or above base one-hot, circular wrap from NUM_CH-1 to 0.
REQ-021 SHALL update base to grant rotated left by 1 (bit NUM_CH-1 wraps to bit 0) on every channel grant; unchanged otherwise.
REQ-022 SHALL keep pri_cnt (4-bit): increment on priority win while req_valid!=0; clear on any channel grant or when req_valid==0 at a priority win.
REQ-023 SHALL force-channel when pri_cnt==PRI_MAX and req_valid!=0: channel granted per REQ-020, pri_ready=0.
REQ-024 SHALL load out_* and out_src from the selected source on the edge following a grant/pri_ready; latency 1 cycle.
REQ-025 SHALL set out_valid=1 after a load; clear to 0 when out_ready=1 and nothing selected; hold out_* stable while out_valid=1 and out_ready=0.
REQ-026 SHALL sustain one command per cycle when out_ready=1 continuously.
REQ-027 SHALL pass req_be/pri_be unmodified, including all-zero byte enables.
REQ-028 SHALL leave base and pri_cnt unchanged in cycles with accept=0.

Reset
REQ-029 SHALL, on rst_n=0 at a clock edge: base=1 (channel 0), pri_cnt=0, out_valid=0, out_addr=0, out_data=0, out_be=0, out_src=0.
REQ-030 SHALL suppress req_grant and pri_ready while rst_n=0; an in-flight out_valid command is dropped by reset.

Verification
REQ-031 SHALL verify: after reset, req_valid=16'h0001, addr 5, data 64'hA5, be 8'hFF, out_ready=1 -> grant=16'h0001 same cycle, next cycle out_valid=1, out_addr=5, out_src=0, base=16'h0002.
REQ-032 SHALL verify: req_valid=16'hFFFF held 18 cycles, out_ready=1 -> grants 0,1,...,15,0,1 one-hot, one per cycle.
REQ-033 SHALL verify: pri_valid=1 and req_valid=16'h0010 held, PRI_MAX=4 -> pri_ready 4 cycles, cycle 5 grant=16'h0010 with pri_ready=0, then priority resumes.
REQ-034 SHALL verify: out_valid=1, out_ready=0 for 3 cycles with requests pending -> req_grant=0, pri_ready=0, out_* stable; out_ready=1 -> next grant same cycle.
REQ-035 SHALL verify: base=16'h8000, req_valid=16'h0003 -> grant=16'h0001 (wrap), base becomes 16'h0002.
REQ-036 SHALL verify: rst_n=0 mid-stream with out_valid=1 -> next cycle out_valid=0, base=16'h0001, pri_cnt=0.
